// File: rtl/pbs_pkg.sv
// Shared types and constants for the PBS battle core: FSM states, move table,
// accuracy LFSR taps and the saturating HP subtract.
package pbs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_P_CALC   = 3'd1,
      ST_P_APPLY  = 3'd2,
      ST_AI_CALC  = 3'd3,
      ST_AI_APPLY = 3'd4,
      ST_OVER     = 3'd5
   } state_e;

   // Entry [i] holds the value for move index i.
   localparam logic [3:0][3:0] MOVE_DMG = {4'd4, 4'd3, 4'd2, 4'd1};
   localparam logic [3:0][3:0] MOVE_ACC = {4'd3, 4'd7, 4'd11, 4'd15};

   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   // Widest HP counter the core supports.
   localparam int unsigned HP_MAX_W = 16;

   function automatic logic [HP_MAX_W-1:0] sat_sub(input logic [HP_MAX_W-1:0] hp,
                                                   input logic [HP_MAX_W-1:0] dmg);
      logic [HP_MAX_W-1:0] res;
      if (dmg >= hp) begin
         res = {HP_MAX_W{1'b0}};
      end else begin
         res = hp - dmg;
      end
      return res;
   endfunction

endpackage

// File: rtl/pbs_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; a zero seed is replaced by 8'h01 so the
// register can never lock up.
module pbs_lfsr8
   import pbs_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] q
);

   localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED_NZ;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/pbs_battle_core.sv
// PBS battle core: one go runs a player attack then an AI attack, with accuracy
// roll, saturating HP bookkeeping and latched victory/loss.
module pbs_battle_core
   import pbs_pkg::*;
#(
   parameter int unsigned HP_W       = 4,
   parameter int unsigned HP_INIT_P  = 9,
   parameter int unsigned HP_INIT_AI = 5,
   parameter int unsigned MOVE_W     = 2,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic [MOVE_W-1:0] p_move,
   input  logic [MOVE_W-1:0] ai_move,
   input  logic              hit_mode,
   output logic [HP_W-1:0]   p_hp,
   output logic [HP_W-1:0]   ai_hp,
   output logic [HP_W-1:0]   last_dmg,
   output logic              last_hit,
   output logic              busy,
   output logic              turn_done,
   output logic              victory,
   output logic              loss
);

   localparam logic [HP_W-1:0] HP_ZERO   = {HP_W{1'b0}};
   localparam logic [HP_W-1:0] HP_RST_P  = HP_W'(HP_INIT_P);
   localparam logic [HP_W-1:0] HP_RST_AI = HP_W'(HP_INIT_AI);

   state_e              state_q, state_d;
   logic [1:0]          pm_q, pm_d, am_q, am_d;
   logic                hit_q, hit_d;
   logic [HP_W-1:0]     dmg_q, dmg_d;
   logic [HP_W-1:0]     p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
   logic [HP_W-1:0]     last_dmg_q, last_dmg_d;
   logic                last_hit_q, last_hit_d;
   logic                busy_q, busy_d;
   logic                turn_done_q, turn_done_d;
   logic                victory_q, victory_d, loss_q, loss_d;

   logic [7:0]          lfsr_s;
   logic [3:0]          unused_lfsr_hi_s;
   logic [1:0]          calc_idx_s;
   logic [HP_W-1:0]     tgt_hp_s, rem_hp_s;
   logic [HP_MAX_W-1:0] mv_dmg_w_s, tgt_w_s, dmg_w_s, sub_w_s;

   pbs_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_s)
   );

   assign unused_lfsr_hi_s = lfsr_s[7:4];

   // Shared attack datapath: move lookup for CALC, saturated HP result for APPLY.
   always_comb begin
      calc_idx_s = pm_q;
      tgt_hp_s   = ai_hp_q;
      if (state_q == ST_AI_CALC) begin
         calc_idx_s = am_q;
      end else begin
         calc_idx_s = pm_q;
      end
      if (state_q == ST_AI_APPLY) begin
         tgt_hp_s = p_hp_q;
      end else begin
         tgt_hp_s = ai_hp_q;
      end
      mv_dmg_w_s            = HP_MAX_W'(MOVE_DMG[calc_idx_s]);
      tgt_w_s               = {HP_MAX_W{1'b0}};
      tgt_w_s[HP_W-1:0]     = tgt_hp_s;
      dmg_w_s               = {HP_MAX_W{1'b0}};
      dmg_w_s[HP_W-1:0]     = dmg_q;
      sub_w_s               = sat_sub(tgt_w_s, dmg_w_s);
      if (hit_q) begin
         rem_hp_s = sub_w_s[HP_W-1:0];
      end else begin
         rem_hp_s = tgt_hp_s;
      end
   end

   // Turn sequencer and register next-state.
   always_comb begin
      state_d     = state_q;
      pm_d        = pm_q;
      am_d        = am_q;
      hit_d       = hit_q;
      dmg_d       = dmg_q;
      p_hp_d      = p_hp_q;
      ai_hp_d     = ai_hp_q;
      last_dmg_d  = last_dmg_q;
      last_hit_d  = last_hit_q;
      turn_done_d = 1'b0;
      victory_d   = victory_q;
      loss_d      = loss_q;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               pm_d    = p_move[1:0];
               am_d    = ai_move[1:0];
               state_d = ST_P_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_P_CALC, ST_AI_CALC: begin
            hit_d = hit_mode | (lfsr_s[3:0] <= MOVE_ACC[calc_idx_s]);
            dmg_d = mv_dmg_w_s[HP_W-1:0];
            if (state_q == ST_P_CALC) begin
               state_d = ST_P_APPLY;
            end else begin
               state_d = ST_AI_APPLY;
            end
         end
         ST_P_APPLY: begin
            ai_hp_d    = rem_hp_s;
            last_dmg_d = ai_hp_q - rem_hp_s;
            last_hit_d = hit_q;
            if (rem_hp_s == HP_ZERO) begin
               victory_d = 1'b1;
               state_d   = ST_OVER;
            end else begin
               state_d = ST_AI_CALC;
            end
         end
         ST_AI_APPLY: begin
            p_hp_d     = rem_hp_s;
            last_dmg_d = p_hp_q - rem_hp_s;
            last_hit_d = hit_q;
            if (rem_hp_s == HP_ZERO) begin
               loss_d  = 1'b1;
               state_d = ST_OVER;
            end else begin
               turn_done_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_OVER: begin
            state_d = ST_OVER;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      case (state_d)
         ST_P_CALC, ST_P_APPLY, ST_AI_CALC, ST_AI_APPLY: busy_d = 1'b1;
         default:                                        busy_d = 1'b0;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pm_q        <= 2'd0;
         am_q        <= 2'd0;
         hit_q       <= 1'b0;
         dmg_q       <= HP_ZERO;
         p_hp_q      <= HP_RST_P;
         ai_hp_q     <= HP_RST_AI;
         last_dmg_q  <= HP_ZERO;
         last_hit_q  <= 1'b0;
         busy_q      <= 1'b0;
         turn_done_q <= 1'b0;
         victory_q   <= 1'b0;
         loss_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pm_q        <= pm_d;
         am_q        <= am_d;
         hit_q       <= hit_d;
         dmg_q       <= dmg_d;
         p_hp_q      <= p_hp_d;
         ai_hp_q     <= ai_hp_d;
         last_dmg_q  <= last_dmg_d;
         last_hit_q  <= last_hit_d;
         busy_q      <= busy_d;
         turn_done_q <= turn_done_d;
         victory_q   <= victory_d;
         loss_q      <= loss_d;
      end
   end

   assign p_hp      = p_hp_q;
   assign ai_hp     = ai_hp_q;
   assign last_dmg  = last_dmg_q;
   assign last_hit  = last_hit_q;
   assign busy      = busy_q;
   assign turn_done = turn_done_q;
   assign victory   = victory_q;
   assign loss      = loss_q;

endmodule

// File: tb/tb_pbs_battle_core.sv
// Directed scoreboard bench for pbs_battle_core: a reference turn model pushes
// per-cycle expected snapshots, which are popped and compared on negedges.
module tb_pbs_battle_core;

   localparam logic [7:0] SEED = 8'hA5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, go, go1, hit_mode;
   logic [1:0] p_move, ai_move;
   logic [3:0] p_hp, ai_hp, last_dmg;
   logic       last_hit, busy, turn_done, victory, loss;
   logic [3:0] p_hp1, ai_hp1, last_dmg1;
   logic       last_hit1, busy1, turn_done1, victory1, loss1;

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct packed {
      logic [3:0] p_hp;
      logic [3:0] ai_hp;
      logic [3:0] last_dmg;
      logic       last_hit;
      logic       busy;
      logic       turn_done;
      logic       victory;
      logic       loss;
   } snap_t;

   snap_t exp_q[$];

   logic [7:0] m_lfsr;
   logic [3:0] m_p_hp, m_ai_hp, m_ldmg;
   logic       m_lhit, m_vic, m_loss;

   pbs_battle_core dut (
      .clk(clk), .rst(rst), .go(go), .p_move(p_move), .ai_move(ai_move),
      .hit_mode(hit_mode), .p_hp(p_hp), .ai_hp(ai_hp), .last_dmg(last_dmg),
      .last_hit(last_hit), .busy(busy), .turn_done(turn_done),
      .victory(victory), .loss(loss)
   );

   pbs_battle_core #(.HP_INIT_P(1)) dut1 (
      .clk(clk), .rst(rst), .go(go1), .p_move(p_move), .ai_move(ai_move),
      .hit_mode(hit_mode), .p_hp(p_hp1), .ai_hp(ai_hp1), .last_dmg(last_dmg1),
      .last_hit(last_hit1), .busy(busy1), .turn_done(turn_done1),
      .victory(victory1), .loss(loss1)
   );

   function automatic logic [7:0] lfsr_nxt(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // Reference accuracy LFSR.
   always @(posedge clk) begin
      if (rst) m_lfsr <= SEED;
      else     m_lfsr <= lfsr_nxt(m_lfsr);
   end

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vec_cnt++;
      assert (obs === expv) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_p_hp = 4'd9; m_ai_hp = 4'd5; m_ldmg = 4'd0;
      m_lhit = 1'b0; m_vic = 1'b0; m_loss = 1'b0;
   endtask

   function automatic snap_t cur_snap();
      snap_t s;
      s.p_hp = m_p_hp; s.ai_hp = m_ai_hp; s.last_dmg = m_ldmg; s.last_hit = m_lhit;
      s.busy = 1'b0; s.turn_done = 1'b0; s.victory = m_vic; s.loss = m_loss;
      return s;
   endfunction

   task automatic move_tab(input logic [1:0] mv, output logic [3:0] dmg, output logic [3:0] acc);
      case (mv)
         2'd0: begin dmg = 4'd1; acc = 4'd15; end
         2'd1: begin dmg = 4'd2; acc = 4'd11; end
         2'd2: begin dmg = 4'd3; acc = 4'd7;  end
         default: begin dmg = 4'd4; acc = 4'd3; end
      endcase
   endtask

   // Push expected snapshots for the six cycles after go is sampled.
   task automatic predict_turn(input logic [1:0] pm, input logic [1:0] am, input logic hm);
      snap_t s;
      logic [7:0] l;
      logic [3:0] dmg, acc, nh;
      logic hit;
      s = cur_snap();
      if (m_vic || m_loss) begin
         repeat (6) exp_q.push_back(s);
         return;
      end
      s.busy = 1'b1;
      exp_q.push_back(s);
      exp_q.push_back(s);
      l = lfsr_nxt(m_lfsr);
      move_tab(pm, dmg, acc);
      hit = hm || (l[3:0] <= acc);
      nh = !hit ? m_ai_hp : ((dmg >= m_ai_hp) ? 4'd0 : m_ai_hp - dmg);
      m_ldmg = m_ai_hp - nh; m_lhit = hit; m_ai_hp = nh;
      s = cur_snap();
      if (nh == 4'd0) begin
         m_vic = 1'b1;
         s.victory = 1'b1;
         repeat (4) exp_q.push_back(s);
         return;
      end
      s.busy = 1'b1;
      exp_q.push_back(s);
      exp_q.push_back(s);
      l = lfsr_nxt(lfsr_nxt(l));
      move_tab(am, dmg, acc);
      hit = hm || (l[3:0] <= acc);
      nh = !hit ? m_p_hp : ((dmg >= m_p_hp) ? 4'd0 : m_p_hp - dmg);
      m_ldmg = m_p_hp - nh; m_lhit = hit; m_p_hp = nh;
      if (nh == 4'd0) m_loss = 1'b1;
      s = cur_snap();
      s.turn_done = (nh != 4'd0);
      exp_q.push_back(s);
      s.turn_done = 1'b0;
      exp_q.push_back(s);
   endtask

   task automatic chk_snap(input string tag);
      snap_t e;
      if (exp_q.size() == 0) begin
         cmp({tag, ".queue_empty"}, 8'd1, 8'd0);
         return;
      end
      e = exp_q.pop_front();
      cmp({tag, ".p_hp"},      8'(p_hp),      8'(e.p_hp));
      cmp({tag, ".ai_hp"},     8'(ai_hp),     8'(e.ai_hp));
      cmp({tag, ".last_dmg"},  8'(last_dmg),  8'(e.last_dmg));
      cmp({tag, ".last_hit"},  8'(last_hit),  8'(e.last_hit));
      cmp({tag, ".busy"},      8'(busy),      8'(e.busy));
      cmp({tag, ".turn_done"}, 8'(turn_done), 8'(e.turn_done));
      cmp({tag, ".victory"},   8'(victory),   8'(e.victory));
      cmp({tag, ".loss"},      8'(loss),      8'(e.loss));
   endtask

   // Called at a negedge in an idle cycle; returns at negedge n+6.
   task automatic do_turn(input string tag, input logic [1:0] pm, input logic [1:0] am, input logic hm);
      p_move = pm; ai_move = am; hit_mode = hm; go = 1'b1;
      predict_turn(pm, am, hm);
      @(posedge clk);
      @(negedge clk);
      go = 1'b0; p_move = ~pm; ai_move = ~am;
      for (int k = 1; k <= 6; k++) begin
         chk_snap($sformatf("%s.c%0d", tag, k));
         if (k < 6) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int td_seen;
      int waited;
      rst = 1'b1; go = 1'b1; go1 = 1'b0; hit_mode = 1'b0; p_move = 2'd0; ai_move = 2'd0;

      // Reset with go held alongside: no turn may start.
      repeat (3) @(negedge clk);
      rst = 1'b0; go = 1'b0;
      model_reset();
      exp_q.push_back(cur_snap());
      chk_snap("reset");
      cmp("reset.dut1_p_hp", 8'(p_hp1), 8'd1);
      @(negedge clk);
      exp_q.push_back(cur_snap());
      chk_snap("rst_go");

      // Basic turn with forced hits.
      do_turn("t1", 2'd1, 2'd0, 1'b1);
      cmp("t1.ai_hp_final", 8'(ai_hp), 8'd3);
      cmp("t1.p_hp_final",  8'(p_hp),  8'd8);

      // Two heavy attacks: saturation, victory, OVER absorbs further go.
      do_reset();
      do_turn("v1", 2'd3, 2'd0, 1'b1);
      cmp("v1.ai_hp", 8'(ai_hp), 8'd1);
      do_turn("v2", 2'd3, 2'd0, 1'b1);
      cmp("v2.victory", 8'(victory),  8'd1);
      cmp("v2.ldmg",    8'(last_dmg), 8'd1);
      cmp("v2.p_hp",    8'(p_hp),     8'd8);
      do_turn("v3", 2'd1, 2'd3, 1'b1);

      // Loss on the HP_INIT_P=1 instance.
      do_reset();
      go1 = 1'b1; hit_mode = 1'b1; p_move = 2'd0; ai_move = 2'd0;
      @(posedge clk);
      @(negedge clk);
      go1 = 1'b0;
      td_seen = 0;
      for (int k = 1; k <= 8; k++) begin
         if (turn_done1) td_seen++;
         if (k == 3) cmp("l.ai_hp", 8'(ai_hp1), 8'd4);
         if (k == 5) begin
            cmp("l.p_hp",    8'(p_hp1),    8'd0);
            cmp("l.loss",    8'(loss1),    8'd1);
            cmp("l.victory", 8'(victory1), 8'd0);
            cmp("l.busy",    8'(busy1),    8'd0);
         end
         @(negedge clk);
      end
      cmp("l.turn_done_seen", 8'(td_seen), 8'd0);

      // Miss: start when the P_CALC roll will exceed move 3 accuracy.
      do_reset();
      waited = 0;
      while (lfsr_nxt(m_lfsr)[3:0] <= 4'd3 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      cmp("m.wait_bound", 8'(waited < 64), 8'd1);
      do_turn("m", 2'd3, 2'd0, 1'b0);
      cmp("m.ai_hp", 8'(ai_hp), 8'd5);

      // go held 10 cycles, rst asserted in AI_CALC and held while go stays high.
      do_reset();
      hit_mode = 1'b1; p_move = 2'd2; ai_move = 2'd1; go = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k <= 3) cmp($sformatf("h.busy%0d", k), 8'(busy), 8'd1);
         if (k == 2) cmp("h.ai_hp_pre", 8'(ai_hp), 8'd5);
         if (k == 3) begin
            cmp("h.ai_hp", 8'(ai_hp), 8'd2);
            rst = 1'b1;
         end
         if (k >= 4) begin
            exp_q.push_back(cur_snap());
            chk_snap($sformatf("h.rst%0d", k));
         end
      end
      @(negedge clk);
      go = 1'b0; rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(cur_snap());
      chk_snap("h.after");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
